registered_n_way_selector: RTL
==============================

Name: registered_n_way_selector

Overview:
- Parametrised successor to the 32-bit 2:1 datapath selector: N-input, WIDTH-bit selector with a registered output and valid/ready handshake on both sides.
- A 2-entry skid buffer decouples upstream and downstream stalls in the multicycle datapath, e.g. ALU operand / register-write-data selection across stall cycles.
- No tristate output; an out-of-range select is an explicit, flagged condition.

Parameters:
- WIDTH, 32, data width of each input and of the output.
- NUM_INPUTS, 4, number of selectable inputs; legal range 2..16.
- SEL_WIDTH, 2, width of Select; must satisfy 2**SEL_WIDTH >= NUM_INPUTS.

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- nReset  input  1  asynchronous, active-low reset.
- DataInputs  input  NUM_INPUTS*WIDTH  flattened inputs; input k occupies bits [k*WIDTH +: WIDTH].
- Select  input  SEL_WIDTH  index of the input to forward; sampled with InValid.
- InValid  input  1  upstream offers DataInputs/Select this cycle.
- InReady  output  1  block can accept this cycle.
- DataOutput  output  WIDTH  selected data, registered.
- OutValid  output  1  DataOutput holds an unconsumed result.
- OutReady  input  1  downstream consumes DataOutput this cycle.
- SelError  output  1  out-of-range select accepted (see Behaviour / Optional Feature).

Behaviour:
- Reset (nReset low, asynchronous): DataOutput=0, OutValid=0, skid entry cleared, SelError=0, state=EMPTY. InReady=1 while in reset and after release.
- Accept = InValid & InReady. Emit = OutValid & OutReady.
- Selection: sel_data = input[Select] if Select < NUM_INPUTS, else all-zero. Captured only on accept.
- States:
  - EMPTY: OutValid=0, InReady=1. Accept -> ONE, output reg <= sel_data.
  - ONE: OutValid=1, InReady=1.
    - Accept & Emit -> ONE, output reg <= sel_data.
    - Accept & !Emit -> FULL, skid <= sel_data, output reg held.
    - !Accept & Emit -> EMPTY.
    - Neither -> hold.
  - FULL: OutValid=1, InReady=0 (registered, from state only). Emit -> ONE, output reg <= skid. Else hold.
- InValid is ignored while InReady=0; no data loss, no duplication.
- Latency: accept in cycle t gives OutValid=1 with that data in cycle t+1 (EMPTY/ONE path). Sustained throughput is 1 transfer/cycle.
- Ordering: strict FIFO, 2 entries max.
- DataOutput and OutValid must be stable while OutValid=1 and OutReady=0.
- InReady has no combinational path from OutReady. OutValid/DataOutput are register outputs.
- SelError (default build): 1-cycle pulse in cycle t+1 when the accept in cycle t had Select >= NUM_INPUTS. Independent of downstream stalls.
- Select with X/Z bits on accept is treated as out-of-range (zero data, SelError).
- Reset mid-transfer discards both entries. No output pulse on reset release.

Optional Feature:
- Macro: SELECTOR_ERR_STICKY_EN.
- Defined: SelError is sticky. It sets on the first out-of-range accept and stays 1 until nReset; later legal transfers do not clear it.
- Undefined: single-cycle pulse per offending accept, as above. Back-to-back offending accepts give SelError high for consecutive cycles.
- Data path behaviour is identical in both builds.

Test Plan:
- Reset/idle: hold nReset=0, then release -> DataOutput=0, OutValid=0, InReady=1, SelError=0. Assert nReset=0 asynchronously mid-cycle -> outputs clear immediately.
- Streaming, OutReady=1: WIDTH=32, NUM_INPUTS=4, inputs 0x11111111/0x22222222/0x33333333/0x44444444, Select 0,1,2,3 on consecutive cycles -> DataOutput sequence 0x11111111..0x44444444 one cycle later, OutValid continuous, InReady never drops.
- Backpressure/skid: accept Select=1 then Select=2 with OutReady=0 -> FULL, InReady=0, DataOutput=0x22222222 held. Offer Select=3 while full -> ignored. Raise OutReady -> outputs 0x22222222 then 0x33333333, no 0x44444444.
- Out-of-range: NUM_INPUTS=3, SEL_WIDTH=2, accept Select=3 -> DataOutput=0 next cycle, SelError 1-cycle pulse. Legal Select=0 next -> SelError=0. With SELECTOR_ERR_STICKY_EN, SelError stays 1 until reset.
- Reset mid-operation: state FULL with two pending words, pulse nReset low -> OutValid=0, InReady=1. No stale word emitted after release.
- Random: random InValid/OutReady/Select for 10k cycles against a scoreboard FIFO model -> every emitted word matches in order, no drops, OutValid/DataOutput stable under stall.

Source files
------------

// File: rtl/registered_n_way_selector_if.sv
// rtl/registered_n_way_selector_if.sv - handshake and data bundle for the registered N-way selector
interface registered_n_way_selector_if #(
  parameter int WIDTH      = 32,
  parameter int NUM_INPUTS = 4,
  parameter int SEL_WIDTH  = 2
);
  logic [NUM_INPUTS*WIDTH-1:0] DataInputs;
  logic [SEL_WIDTH-1:0]        Select;
  logic                        InValid;
  logic                        InReady;
  logic [WIDTH-1:0]            DataOutput;
  logic                        OutValid;
  logic                        OutReady;
  logic                        SelError;

  // Environment side: offers inputs and consumes the registered result.
  modport master (
    output DataInputs, Select, InValid, OutReady,
    input  InReady, DataOutput, OutValid, SelError
  );

  // Selector side.
  modport slave (
    input  DataInputs, Select, InValid, OutReady,
    output InReady, DataOutput, OutValid, SelError
  );
endinterface

// File: rtl/registered_n_way_selector.sv
// rtl/registered_n_way_selector.sv - N-way WIDTH-bit selector with registered output and 2-entry skid buffer
// Optional build macro: SELECTOR_ERR_STICKY_EN (SelError holds until reset instead of pulsing).
module registered_n_way_selector #(
  parameter int WIDTH      = 32,
  parameter int NUM_INPUTS = 4,
  parameter int SEL_WIDTH  = 2
) (
  input  logic                       CLK,
  input  logic                       nReset,
  registered_n_way_selector_if.slave sel_if
);
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] sel_data;
  logic             sel_ok;
  logic [31:0]      sel_idx;
  logic             in_ready;
  logic             out_valid;
  logic             accept;
  logic             emit;

  // Ready depends only on the state register, so OutReady never reaches InReady combinationally.
  assign in_ready  = (state_q != ST_FULL);
  assign out_valid = (state_q != ST_EMPTY);
  assign accept    = sel_if.InValid & in_ready;
  assign emit      = out_valid & sel_if.OutReady;
  assign sel_idx   = 32'(sel_if.Select);

  // Input mux; an out-of-range or unknown select yields zero data and sel_ok=0.
  always_comb begin
    sel_ok   = 1'b0;
    sel_data = '0;
    if (sel_idx < NUM_INPUTS) begin
      sel_ok = 1'b1;
    end
    for (int k = 0; k < NUM_INPUTS; k++) begin
      if (sel_ok && (sel_idx == k)) begin
        sel_data = sel_if.DataInputs[k*WIDTH +: WIDTH];
      end
    end
  end

`ifdef SELECTOR_ERR_STICKY_EN
  assign err_d = err_q | (accept & ~sel_ok);
`else
  assign err_d = accept & ~sel_ok;
`endif

  // Next-state and datapath steering for the output register and skid entry.
  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    skid_d  = skid_q;
    case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          state_d = ST_ONE;
          out_d   = sel_data;
        end
      end
      ST_ONE: begin
        if (accept && emit) begin
          out_d = sel_data;
        end else if (accept) begin
          state_d = ST_FULL;
          skid_d  = sel_data;
        end else if (emit) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (emit) begin
          state_d = ST_ONE;
          out_d   = skid_q;
        end
      end
      default: begin
        state_d = ST_EMPTY;
      end
    endcase
  end

  // State, output, skid and error registers; reset discards everything in flight.
  always_ff @(posedge CLK or negedge nReset) begin
    if (!nReset) begin
      state_q <= ST_EMPTY;
      out_q   <= '0;
      skid_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      skid_q  <= skid_d;
      err_q   <= err_d;
    end
  end

  assign sel_if.InReady    = in_ready;
  assign sel_if.OutValid   = out_valid;
  assign sel_if.DataOutput = out_q;
  assign sel_if.SelError   = err_q;
endmodule
